// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo: parameterised UART receiver with a receive FIFO.
//   Serial frames on rx (start, DATA_BITS data LSB first, optional parity,
//   STOP_BITS stop bits) are sampled mid-bit. Good characters are pushed
//   into a FIFO. Bad characters set sticky error flags instead.
// Ports:
//   clk, rst        clock, synchronous active-high reset
//   bc              bit period minus one, in clk cycles (>= 3)
//   rx              asynchronous serial input, idle high
//   rd_vld/rd_data  FIFO head; popped when rd_vld & rd_rdy
//   rd_rdy          consumer ready
//   count, full     FIFO occupancy
//   term_hit        one-cycle pulse when a good TERM_CHAR is received
//   frame_err, parity_err, overrun  sticky flags, cleared by err_clr
module uart_rx_fifo #(
  parameter int          DATA_BITS  = 8,
  parameter int          PARITY     = 0,
  parameter int          STOP_BITS  = 1,
  parameter int          FIFO_DEPTH = 8,
  parameter int          TERM_EN    = 1,
  parameter logic [7:0]  TERM_CHAR  = 8'h10,
  localparam int         CW         = $clog2(FIFO_DEPTH + 1)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [15:0]          bc,
  input  logic                 rx,
  output logic                 rd_vld,
  output logic [DATA_BITS-1:0] rd_data,
  input  logic                 rd_rdy,
  output logic [CW-1:0]        count,
  output logic                 full,
  output logic                 term_hit,
  output logic                 frame_err,
  output logic                 parity_err,
  output logic                 overrun,
  input  logic                 err_clr
);
  localparam int AW = $clog2(FIFO_DEPTH);

  typedef enum logic [2:0] {IDLE, START, DATA, PAR, STOP, BRK} state_t;

  // ---------------------------------------------------------------
  // Synchroniser plus one extra flop for falling-edge detection
  // ---------------------------------------------------------------
  logic rx_meta, rxs, rxs_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      rx_meta <= 1'b1;
      rxs     <= 1'b1;
      rxs_d   <= 1'b1;
    end else begin
      rx_meta <= rx;
      rxs     <= rx_meta;
      rxs_d   <= rxs;
    end
  end

  // (bc+1)>>1 without a 17-bit intermediate
  logic [15:0] p_half;
  assign p_half = (bc >> 1) + {15'd0, bc[0]};

  // ---------------------------------------------------------------
  // Receive FSM
  // ---------------------------------------------------------------
  state_t               state_q, state_d;
  logic [15:0]          cnt_q, cnt_d;
  logic [2:0]           bit_q, bit_d;
  logic [DATA_BITS-1:0] sh_q, sh_d;
  logic                 bpar_q, bpar_d;
  logic                 bfrm_q, bfrm_d;
  logic                 push_d, term_d, fe_set, pe_set;
  logic                 push_q;
  logic                 tick, frm;

  assign tick = (cnt_q == 16'd0);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    bit_d   = bit_q;
    sh_d    = sh_q;
    bpar_d  = bpar_q;
    bfrm_d  = bfrm_q;
    push_d  = 1'b0;
    term_d  = 1'b0;
    fe_set  = 1'b0;
    pe_set  = 1'b0;
    frm     = bfrm_q | ~rxs;
    // every timed state counts down and reloads a full period at expiry
    if (state_q != IDLE && state_q != BRK) begin
      cnt_d = tick ? bc : cnt_q - 16'd1;
    end
    case (state_q)
      IDLE: begin
        if (rxs_d && !rxs) begin
          state_d = START;
          cnt_d   = p_half;
          bit_d   = 3'd0;
          bpar_d  = 1'b0;
          bfrm_d  = 1'b0;
        end
      end
      START: begin
        if (tick) state_d = rxs ? IDLE : DATA;  // high at mid-start = glitch
      end
      DATA: begin
        if (tick) begin
          sh_d = {rxs, sh_q[DATA_BITS-1:1]};
          if (bit_q == 3'(DATA_BITS - 1)) begin
            bit_d   = 3'd0;
            state_d = (PARITY != 0) ? PAR : STOP;
          end else begin
            bit_d = bit_q + 3'd1;
          end
        end
      end
      PAR: begin
        if (tick) begin
          // xor over data+parity must be 0 for even, 1 for odd
          bpar_d  = (^sh_q) ^ rxs ^ (PARITY == 2);
          state_d = STOP;
        end
      end
      STOP: begin
        if (tick) begin
          bfrm_d = frm;
          if (bit_q == 3'(STOP_BITS - 1)) begin
            state_d = IDLE;
            if (frm) begin
              fe_set = 1'b1;
              if (sh_q == '0) state_d = BRK;  // line held low: break
            end else if (bpar_q) begin
              pe_set = 1'b1;
            end else begin
              push_d = 1'b1;
              term_d = (TERM_EN != 0) && (sh_q == TERM_CHAR[DATA_BITS-1:0]);
            end
          end else begin
            bit_d = bit_q + 3'd1;
          end
        end
      end
      BRK: begin
        if (rxs) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      bit_q    <= '0;
      sh_q     <= '0;
      bpar_q   <= 1'b0;
      bfrm_q   <= 1'b0;
      push_q   <= 1'b0;
      term_hit <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      bit_q    <= bit_d;
      sh_q     <= sh_d;
      bpar_q   <= bpar_d;
      bfrm_q   <= bfrm_d;
      push_q   <= push_d;
      term_hit <= term_d;
    end
  end

  // ---------------------------------------------------------------
  // Receive FIFO. sh_q still holds the character during the push
  // cycle: the next DATA sample is at least a bit period away.
  // ---------------------------------------------------------------
  logic [DATA_BITS-1:0] mem [FIFO_DEPTH];
  logic [AW-1:0]        wr_ptr, rd_ptr;
  logic                 do_push, do_pop, ov_set;

  assign rd_vld  = (count != '0);
  assign full    = (count == CW'(FIFO_DEPTH));
  assign rd_data = mem[rd_ptr];
  assign do_pop  = rd_vld & rd_rdy;
  // a same-cycle pop frees the slot a full FIFO needs
  assign do_push = push_q & (~full | do_pop);
  assign ov_set  = push_q & full & ~do_pop;

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < FIFO_DEPTH; i++) mem[i] <= '0;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      frame_err  <= 1'b0;
      parity_err <= 1'b0;
      overrun    <= 1'b0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= sh_q;
        wr_ptr      <= wr_ptr + AW'(1);
      end
      if (do_pop) rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
      // a new error in the clear cycle wins
      frame_err  <= fe_set | (frame_err  & ~err_clr);
      parity_err <= pe_set | (parity_err & ~err_clr);
      overrun    <= ov_set | (overrun    & ~err_clr);
    end
  end
endmodule
